// File: rtl/pwm_setpoint_sequencer.sv
// Slew-limited setpoint sequencer feeding the half-bridge PWM block.
// Steps current toward target once per period using invalidate/load/complete.
//
// state          | meaning
// IDLE           | no step pending; accepts new targets
// WAIT_SLOT      | step pending; waits for tick_counter == load_tick
// INVALIDATE     | pwm_invalidate pulse, new counts already on outputs
// LOAD           | pwm_load pulse
// WAIT_COMPLETE  | waits for calculation_complete with timeout
// ERROR          | sticky fault; only reset exits
module pwm_setpoint_sequencer #(
  parameter int tick_count_period = 100,
  parameter int bitwidth          = $clog2(tick_count_period + 1) + 1,
  parameter int max_step          = 4,
  parameter int load_tick         = 80,
  parameter int timeout_ticks     = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [bitwidth-1:0] tick_counter,
  input  logic                request_valid,
  output logic                request_ready,
  input  logic [bitwidth-1:0] request_highside,
  input  logic [bitwidth-1:0] request_lowside,
  output logic                request_rejected,
  output logic [bitwidth-1:0] pwm_tick_count_highside,
  output logic [bitwidth-1:0] pwm_tick_count_lowside,
  output logic                pwm_invalidate,
  output logic                pwm_load,
  input  logic                pwm_calculation_complete,
  input  logic                pwm_calculation_error,
  output logic                busy,
  output logic                target_reached,
  output logic                sequencer_error
);

  localparam logic [2:0] IDLE          = 3'd0;
  localparam logic [2:0] WAIT_SLOT     = 3'd1;
  localparam logic [2:0] INVALIDATE    = 3'd2;
  localparam logic [2:0] LOAD          = 3'd3;
  localparam logic [2:0] WAIT_COMPLETE = 3'd4;
  localparam logic [2:0] ERROR         = 3'd5;

  localparam int timeout_w    = $clog2(timeout_ticks + 1);
  localparam int timeout_last = timeout_ticks - 1;

  localparam logic [bitwidth:0]     period_wide  = tick_count_period[bitwidth:0];
  localparam logic [bitwidth-1:0]   period_b     = tick_count_period[bitwidth-1:0];
  localparam logic [bitwidth-1:0]   step_b       = max_step[bitwidth-1:0];
  localparam logic [bitwidth-1:0]   load_tick_b  = load_tick[bitwidth-1:0];
  localparam logic [timeout_w-1:0]  timeout_init = timeout_last[timeout_w-1:0];

  // The step must finish (invalidate, load, worst-case completion) before the period wraps.
  if (load_tick + 3 + timeout_ticks >= tick_count_period || max_step < 1) begin : g_bad_params
    $error("pwm_setpoint_sequencer: load_tick/timeout_ticks/max_step do not fit the period");
  end

  logic [2:0]           state;
  logic [bitwidth-1:0]  target_hs, target_ls;
  logic [bitwidth-1:0]  current_hs, current_ls;
  logic [timeout_w-1:0] timeout_cnt;

  logic [bitwidth:0]    request_sum;
  logic                 request_over;
  logic                 accept;
  logic                 accept_ok;
  logic [bitwidth-1:0]  hs_raw, ls_raw, hs_room, ls_room, next_hs, next_ls;

  function automatic logic [bitwidth-1:0] step_toward(input logic [bitwidth-1:0] cur,
                                                      input logic [bitwidth-1:0] tgt);
    logic [bitwidth-1:0] diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return (diff > step_b) ? cur + step_b : tgt;
    end else begin
      diff = cur - tgt;
      return (diff > step_b) ? cur - step_b : tgt;
    end
  endfunction

  always_comb begin
    request_sum  = {1'b0, request_highside} + {1'b0, request_lowside};
    request_over = request_sum > period_wide;
    accept       = request_valid && request_ready;
    accept_ok    = accept && !request_over;

    hs_raw  = step_toward(current_hs, target_hs);
    ls_raw  = step_toward(current_ls, target_ls);
    hs_room = period_b - ls_raw;
    ls_room = period_b - hs_raw;
    // Decreases apply in full; only an increasing channel yields to keep the sum in range.
    next_hs = (hs_raw > current_hs && hs_raw > hs_room) ? hs_room : hs_raw;
    next_ls = (ls_raw > current_ls && ls_raw > ls_room) ? ls_room : ls_raw;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                   <= IDLE;
      target_hs               <= '0;
      target_ls               <= '0;
      current_hs              <= '0;
      current_ls              <= '0;
      pwm_tick_count_highside <= '0;
      pwm_tick_count_lowside  <= '0;
      request_rejected        <= 1'b0;
      sequencer_error         <= 1'b0;
      timeout_cnt             <= '0;
    end else begin
      request_rejected <= 1'b0;
      if (accept && request_over) request_rejected <= 1'b1;
      if (accept_ok) begin
        target_hs <= request_highside;
        target_ls <= request_lowside;
      end

      if (pwm_calculation_error) begin
        state           <= ERROR;
        sequencer_error <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (accept_ok && {request_highside, request_lowside} != {current_hs, current_ls})
              state <= WAIT_SLOT;
          end
          WAIT_SLOT: begin
            if (tick_counter == load_tick_b) begin
              if ({target_hs, target_ls} == {current_hs, current_ls}) begin
                // A fresh target arriving in the same cycle keeps the slot wait alive.
                if (!(accept_ok && {request_highside, request_lowside} != {current_hs, current_ls}))
                  state <= IDLE;
              end else begin
                pwm_tick_count_highside <= next_hs;
                pwm_tick_count_lowside  <= next_ls;
                state                   <= INVALIDATE;
              end
            end
          end
          INVALIDATE: state <= LOAD;
          LOAD: begin
            timeout_cnt <= timeout_init;
            state       <= WAIT_COMPLETE;
          end
          WAIT_COMPLETE: begin
            if (pwm_calculation_complete) begin
              current_hs <= pwm_tick_count_highside;
              current_ls <= pwm_tick_count_lowside;
              if ({pwm_tick_count_highside, pwm_tick_count_lowside} == {target_hs, target_ls})
                state <= IDLE;
              else
                state <= WAIT_SLOT;
            end else if (timeout_cnt == '0) begin
              state           <= ERROR;
              sequencer_error <= 1'b1;
            end else begin
              timeout_cnt <= timeout_cnt - 1'b1;
            end
          end
          ERROR: state <= ERROR;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign request_ready  = (state == IDLE) || (state == WAIT_SLOT);
  assign pwm_invalidate = (state == INVALIDATE);
  assign pwm_load       = (state == LOAD);
  assign busy           = (state != IDLE);
  assign target_reached = (state == IDLE) && ({current_hs, current_ls} == {target_hs, target_ls});

endmodule
